// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter: default sizing and
// the round-robin pick function.
package mem_arb_pkg;
  localparam int NUM_REQ_DEF   = 2;
  localparam int ADDR_W_DEF    = 64;
  localparam int DATA_W_DEF    = 64;
  localparam int MAX_OUTST_DEF = 4;
  localparam int ID_W  = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST_DEF) + 1;
  localparam int RR_MAX = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit at or after ptr, wrapping modulo n; lowest offset wins.
  function automatic pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                    input logic [2:0] ptr, input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int i = RR_MAX-1; i >= 0; i--) begin
      j = (int'(ptr) + i) % n;
      if (i < n && req[j]) begin
        p.found = 1'b1;
        p.idx   = 3'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory transactions.
module mem_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one OBI-style memory port among NUM_REQ
// requesters, with in-order response routing through an ID FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int BE_W      = DATA_W/8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ*BE_W-1:0]     be_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mst_req_o,
  output logic [ADDR_W-1:0]           mst_addr_o,
  output logic                        mst_we_o,
  output logic [BE_W-1:0]             mst_be_o,
  output logic [DATA_W-1:0]           mst_wdata_o,
  input  logic                        mst_gnt_i,
  input  logic                        mst_rvalid_i,
  input  logic [DATA_W-1:0]           mst_rdata_i,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt_o,
  output logic                        proto_err_o
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [SEL_W-1:0]  rr_ptr, locked_idx, sel, head;
  logic              lock, full, empty, hs, pop;
  logic [RR_MAX-1:0] req_pad;
  pick_t             pick;

  // A stalled request keeps its selection so the payload cannot change.
  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req_i;
    pick = rr_pick(req_pad, 3'(rr_ptr), NUM_REQ);
    sel  = lock ? locked_idx : (pick.found ? SEL_W'(pick.idx) : '0);
  end

  assign mst_req_o   = (|req_i) & req_i[sel] & ~full;
  assign hs          = mst_req_o & mst_gnt_i;
  assign pop         = mst_rvalid_i & ~empty;
  assign mst_addr_o  = mst_req_o ? addr_i[int'(sel)*ADDR_W +: ADDR_W]  : '0;
  assign mst_we_o    = mst_req_o ? we_i[sel]                           : 1'b0;
  assign mst_be_o    = mst_req_o ? be_i[int'(sel)*BE_W +: BE_W]        : '0;
  assign mst_wdata_o = mst_req_o ? wdata_i[int'(sel)*DATA_W +: DATA_W] : '0;
  assign rdata_o     = pop ? mst_rdata_i : '0;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs)  gnt_o[sel]     = 1'b1;
    if (pop) rvalid_o[head] = 1'b1;
  end

  mem_arb_id_fifo #(.DEPTH(MAX_OUTST), .WIDTH(SEL_W)) u_id_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (hs),
    .pop      (pop),
    .data_in  (sel),
    .data_out (head),
    .full     (full),
    .empty    (empty),
    .count    (outst_cnt_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      lock        <= 1'b0;
      locked_idx  <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr <= (int'(sel) == NUM_REQ-1) ? '0 : sel + 1'b1;
        lock   <= 1'b0;
      end else if (mst_req_o) begin
        lock       <= 1'b1;
        locked_idx <= sel;
      end
      if (mst_rvalid_i & empty) proto_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_mem_port_arbiter;
  localparam int N = 2, AW = 64, DW = 64, MO = 4, BW = DW/8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_i = '0, we_i = '0;
  logic [N*AW-1:0]   addr_i = '0;
  logic [N*BW-1:0]   be_i = '0;
  logic [N*DW-1:0]   wdata_i = '0;
  logic [N-1:0]      gnt_o, rvalid_o;
  logic [DW-1:0]     rdata_o, mst_wdata_o, mst_rdata_i = '0;
  logic              mst_req_o, mst_we_o, proto_err_o;
  logic              mst_gnt_i = 1'b0, mst_rvalid_i = 1'b0;
  logic [AW-1:0]     mst_addr_o;
  logic [BW-1:0]     mst_be_o;
  logic [$clog2(MO):0] outst_cnt_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mst_req_o(mst_req_o), .mst_addr_o(mst_addr_o),
    .mst_we_o(mst_we_o), .mst_be_o(mst_be_o), .mst_wdata_o(mst_wdata_o),
    .mst_gnt_i(mst_gnt_i), .mst_rvalid_i(mst_rvalid_i), .mst_rdata_i(mst_rdata_i),
    .outst_cnt_o(outst_cnt_o), .proto_err_o(proto_err_o)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of issuer IDs, round-robin pointer, pending lock.
  int           m_ptr = 0, m_locked = 0;
  bit           m_lock = 0, m_perr = 0;
  int           q[$];
  logic [N-1:0] m_last_gnt = '0;

  function automatic void model_eval(output int sel, output bit mreq,
                                     output logic [N-1:0] g, output logic [N-1:0] rv);
    sel = 0;
    if (m_lock) sel = m_locked;
    else for (int i = N-1; i >= 0; i--) if (req_i[(m_ptr+i)%N]) sel = (m_ptr+i)%N;
    mreq = (req_i != 0) && req_i[sel] && (q.size() < MO);
    g = '0;
    if (mreq && mst_gnt_i) g[sel] = 1'b1;
    rv = '0;
    if (mst_rvalid_i && q.size() > 0) rv[q[0]] = 1'b1;
  endfunction

  initial begin
    int s; bit mr; logic [N-1:0] g, rv; int pre;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ptr = 0; m_lock = 0; m_locked = 0; m_perr = 0; q.delete(); m_last_gnt = '0;
      end else begin
        model_eval(s, mr, g, rv);
        pre = q.size();
        m_last_gnt = g;
        if (mst_rvalid_i) begin
          if (pre > 0) void'(q.pop_front());
          else m_perr = 1;
        end
        if (g != 0) begin
          q.push_back(s); m_ptr = (s+1)%N; m_lock = 0;
        end else if (mr) begin
          m_lock = 1; m_locked = s;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int s; bit mr; logic [N-1:0] g, rv;
    model_eval(s, mr, g, rv);
    chk("gnt", gnt_o, g);
    chk("rvalid", rvalid_o, rv);
    chk("rdata", rdata_o, (rv != 0) ? mst_rdata_i : 64'h0);
    chk("mst_req", mst_req_o, mr);
    chk("mst_addr", mst_addr_o, mr ? addr_i[s*AW +: AW] : 64'h0);
    chk("mst_we", mst_we_o, mr ? we_i[s] : 1'b0);
    chk("mst_be", mst_be_o, mr ? be_i[s*BW +: BW] : 8'h0);
    chk("mst_wdata", mst_wdata_o, mr ? wdata_i[s*DW +: DW] : 64'h0);
    chk("outst_cnt", outst_cnt_o, q.size());
    chk("proto_err", proto_err_o, m_perr);
  end

  task automatic cyc(input logic [1:0] r, input logic g, input logic rv, input logic [63:0] rd,
                     input logic [1:0] eg, input logic [1:0] erv, input int ecnt,
                     input logic emr, input logic [63:0] ea, input logic ep);
    req_i = r; mst_gnt_i = g; mst_rvalid_i = rv; mst_rdata_i = rd;
    @(negedge clk);
    chk("d_gnt", gnt_o, eg);
    chk("d_rvalid", rvalid_o, erv);
    if (erv != 0) chk("d_rdata", rdata_o, rd);
    chk("d_cnt", outst_cnt_o, ecnt);
    chk("d_mreq", mst_req_o, emr);
    chk("d_addr", mst_addr_o, ea);
    chk("d_perr", proto_err_o, ep);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_i = '0; mst_gnt_i = 0; mst_rvalid_i = 0; mst_rdata_i = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_mreq", mst_req_o, 0);
    chk("rst_cnt", outst_cnt_o, 0);
    chk("rst_perr", proto_err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bit pend [N];
    #1;
    addr_i  = {64'h100, 64'h40};
    be_i    = {8'hFF, 8'hFF};
    wdata_i = {64'h2222, 64'h1111};
    do_reset();

    // single requester, responses two cycles after each grant
    cyc(2'b01, 1, 0, 64'h0,  2'b01, 2'b00, 0, 1, 64'h40, 0);
    cyc(2'b01, 1, 0, 64'h0,  2'b01, 2'b00, 1, 1, 64'h40, 0);
    cyc(2'b01, 1, 1, 64'hA0, 2'b01, 2'b01, 2, 1, 64'h40, 0);
    cyc(2'b00, 1, 1, 64'hA1, 2'b00, 2'b01, 2, 0, 64'h0,  0);
    cyc(2'b00, 1, 1, 64'hA2, 2'b00, 2'b01, 1, 0, 64'h0,  0);
    cyc(2'b00, 0, 0, 64'h0,  2'b00, 2'b00, 0, 0, 64'h0,  0);

    // both requesting: alternation and in-order routing
    do_reset();
    cyc(2'b11, 1, 0, 64'h0,  2'b01, 2'b00, 0, 1, 64'h40,  0);
    cyc(2'b11, 1, 1, 64'h10, 2'b10, 2'b01, 1, 1, 64'h100, 0);
    cyc(2'b11, 1, 1, 64'h11, 2'b01, 2'b10, 1, 1, 64'h40,  0);
    cyc(2'b11, 1, 1, 64'h12, 2'b10, 2'b01, 1, 1, 64'h100, 0);
    cyc(2'b00, 1, 1, 64'h13, 2'b00, 2'b10, 1, 0, 64'h0,   0);
    cyc(2'b00, 0, 0, 64'h0,  2'b00, 2'b00, 0, 0, 64'h0,   0);

    // lock holds r1 while memory stalls
    do_reset();
    cyc(2'b10, 0, 0, 64'h0, 2'b00, 2'b00, 0, 1, 64'h100, 0);
    cyc(2'b11, 0, 0, 64'h0, 2'b00, 2'b00, 0, 1, 64'h100, 0);
    cyc(2'b11, 0, 0, 64'h0, 2'b00, 2'b00, 0, 1, 64'h100, 0);
    cyc(2'b11, 1, 0, 64'h0, 2'b10, 2'b00, 0, 1, 64'h100, 0);
    cyc(2'b01, 1, 0, 64'h0, 2'b01, 2'b00, 1, 1, 64'h40,  0);
    cyc(2'b00, 0, 1, 64'h5, 2'b00, 2'b10, 2, 0, 64'h0,   0);
    cyc(2'b00, 0, 1, 64'h6, 2'b00, 2'b01, 1, 0, 64'h0,   0);
    cyc(2'b00, 0, 0, 64'h0, 2'b00, 2'b00, 0, 0, 64'h0,   0);

    // full FIFO blocks grants; a pop unblocks only on the following cycle
    do_reset();
    for (int i = 0; i < 4; i++) cyc(2'b01, 1, 0, 64'h0, 2'b01, 2'b00, i, 1, 64'h40, 0);
    cyc(2'b01, 1, 0, 64'h0, 2'b00, 2'b00, 4, 0, 64'h0,  0);
    cyc(2'b01, 1, 1, 64'h7, 2'b00, 2'b01, 4, 0, 64'h0,  0);
    cyc(2'b01, 1, 0, 64'h0, 2'b01, 2'b00, 3, 1, 64'h40, 0);
    cyc(2'b00, 0, 0, 64'h0, 2'b00, 2'b00, 4, 0, 64'h0,  0);

    // spurious response sets a sticky error
    do_reset();
    cyc(2'b00, 0, 1, 64'h9, 2'b00, 2'b00, 0, 0, 64'h0, 0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 0, 0, 64'h0, 2'b00, 2'b00, 0, 0, 64'h0, 1);

    // reset with two outstanding, then r0 wins and a late response errors
    do_reset();
    cyc(2'b01, 1, 0, 64'h0, 2'b01, 2'b00, 0, 1, 64'h40, 0);
    cyc(2'b01, 1, 0, 64'h0, 2'b01, 2'b00, 1, 1, 64'h40, 0);
    do_reset();
    cyc(2'b11, 1, 0, 64'h0, 2'b01, 2'b00, 0, 1, 64'h40, 0);
    cyc(2'b00, 0, 1, 64'h3, 2'b00, 2'b01, 1, 0, 64'h0,  0);
    cyc(2'b00, 0, 1, 64'h4, 2'b00, 2'b00, 0, 0, 64'h0,  0);
    cyc(2'b00, 0, 0, 64'h0, 2'b00, 2'b00, 0, 0, 64'h0,  1);

    // randomized traffic; requesters hold payload until granted
    do_reset();
    for (int k = 0; k < N; k++) pend[k] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (m_last_gnt[k]) pend[k] = 0;
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1;
          addr_i[k*AW +: AW]  = {$urandom, $urandom};
          we_i[k]             = 1'($urandom);
          be_i[k*BW +: BW]    = 8'($urandom);
          wdata_i[k*DW +: DW] = {$urandom, $urandom};
        end
        req_i[k] = pend[k];
      end
      mst_gnt_i    = ($urandom_range(0, 3) != 0);
      mst_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mst_rdata_i  = {$urandom, $urandom};
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single memory-subsystem data port among NUM_REQ requesters, e.g. the CPU data port plus a debug or DMA master.
- Sits between the requesters and the memory subsystem in the MCU top level.
- Both sides use an OBI-style request/grant/rvalid handshake.
- A response-ID FIFO tracks up to MAX_OUTST in-order outstanding transactions, so each response is routed back to its issuer.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 64: address width.
- DATA_W, 64: data width. BE_W = DATA_W/8.
- MAX_OUTST, 4: maximum in-flight transactions (power of 2, >=2).

Ports:
- clk_i  in  1  system clock; the block has one clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request.
- addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at slice k.
- we_i  in  NUM_REQ  write enable.
- be_i  in  NUM_REQ*BE_W  byte enables.
- wdata_i  in  NUM_REQ*DATA_W  write data.
- gnt_o  out  NUM_REQ  one-hot grant.
- rvalid_o  out  NUM_REQ  one-hot response valid.
- rdata_o  out  DATA_W  response data, broadcast to all requesters.
- mst_req_o  out  1  request to memory.
- mst_addr_o  out  ADDR_W  muxed address.
- mst_we_o  out  1  muxed write enable.
- mst_be_o  out  BE_W  muxed byte enables.
- mst_wdata_o  out  DATA_W  muxed write data.
- mst_gnt_i  in  1  memory grant.
- mst_rvalid_i  in  1  memory response valid.
- mst_rdata_i  in  DATA_W  memory response data.
- outst_cnt_o  out  $clog2(MAX_OUTST)+1  in-flight count.
- proto_err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_i=1):
  - rr_ptr=0, lock=0, FIFO empty, outst_cnt_o=0, proto_err_o=0.
  - All combinational outputs evaluate to 0 because the FIFO is empty and there is no lock.
- Selection (combinational):
  - If lock=0, sel = first k with req_i[k]=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - If lock=1, sel = locked_idx.
- mst_req_o = req_i[sel] & any-request & ~fifo_full.
  - fifo_full is registered state. A pop in the same cycle does NOT unblock a grant; the grant resumes the next cycle.
- mst_addr/we/be/wdata are driven from the sel slice. When mst_req_o=0 they are 0.
- Lock:
  - If mst_req_o=1 and mst_gnt_i=0, the next state is lock=1 with locked_idx=sel.
  - Selection is held until the handshake, so a higher-priority arrival cannot change the address mid-request.
  - Requesters must hold req and payload until granted. This is not checked.
- Handshake (mst_req_o & mst_gnt_i), zero added latency:
  - gnt_o[sel]=1 in the same cycle.
  - sel is pushed into the FIFO.
  - rr_ptr <= (sel+1) mod NUM_REQ.
  - lock <= 0.
- Response:
  - On mst_rvalid_i, rvalid_o[fifo_head]=1 in the same cycle, rdata_o=mst_rdata_i, and the FIFO pops.
  - Responses return in order; one response per cycle maximum.
- Simultaneous push and pop: both take effect and outst_cnt_o is unchanged.
- Response with empty FIFO:
  - rvalid_o stays all zero and the response is dropped.
  - proto_err_o <= 1, sticky until reset.
- Counter: outst_cnt_o = FIFO occupancy, range 0..MAX_OUTST, registered.
- Pointers wrap modulo MAX_OUTST. An extra occupancy bit distinguishes full from empty.
- Reset mid-transaction: all outstanding IDs are discarded. Late responses after reset set proto_err_o.
- Only a single cycle of rr_ptr state is kept; fairness guarantees each waiting requester a grant within NUM_REQ handshakes.

Decomposition:
- Package mem_arb_pkg holds:
  - localparams ID_W=$clog2(NUM_REQ) (min 1) and CNT_W.
  - A function rr_pick(req vector, ptr) returning an index and a found flag.
- Sub-module mem_arb_id_fifo:
  - Parameters DEPTH and WIDTH; ports push/pop/data/full/empty/count.
  - Async active-high reset, same clock.

Test Plan:
- Single requester (r0 only): 3 back-to-back reads, mst_gnt_i=1 every cycle, memory responds 2 cycles later with 0xA0,0xA1,0xA2 -> gnt_o=01 for 3 cycles; rvalid_o[0] carries the 3 data values in order; outst_cnt_o peaks at 2 and returns to 0.
- Both request continuously, gnt always 1 -> grants alternate r0,r1,r0,r1. Responses 0x10..0x13 route to rvalid_o pattern 01,10,01,10.
- Lock: r1 requests addr 0x100 with mst_gnt_i held 0 for 3 cycles; r0 raises req on cycle 1 -> mst_addr_o stays 0x100 throughout. On the gnt cycle gnt_o=10, and r0 is granted next.
- Full: MAX_OUTST=4, 4 grants with no responses -> outst_cnt_o=4 and mst_req_o=0 while req_i=01. A response arrives -> no grant that cycle; a grant the following cycle; count returns 4->3->4.
- Spurious mst_rvalid_i with empty FIFO -> rvalid_o=00 and proto_err_o=1, persisting until rst_i.
- Assert rst_i with 2 outstanding -> outst_cnt_o=0, gnt_o=0, rr_ptr=0. After release, a simultaneous r0/r1 request grants r0 first.
